// File: rtl/inst_rom_resp.sv
// Instruction ROM with a 1-cycle registered fetch port, a program-load write
// port, an IDLE/RUN/HALT fetch FSM and a saturating fetch counter.
module inst_rom_resp #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i_ROM,
  input  logic        reset_i_ROM,
  input  logic        chip_enable_i_ROM,
  input  logic [31:0] pc_addr_i_ROM,
  input  logic        load_en_i_ROM,
  input  logic [31:0] load_addr_i_ROM,
  input  logic [31:0] load_data_i_ROM,
  output logic [31:0] inst_o_ROM,
  output logic        inst_valid_o_ROM,
  output logic        addr_fault_o_ROM,
  output logic        load_err_o_ROM,
  output logic [15:0] fetch_cnt_o_ROM,
  output logic [1:0]  state_o_ROM
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    BAD  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH];

  logic pc_in_range, ld_in_range;
  logic fetch_ok, fetch_oob, fetch_nop, load_ok, load_bad;

  // Full 32-bit compares: high address bits must never alias into the array.
  assign pc_in_range = (pc_addr_i_ROM < DEPTH_W);
  assign ld_in_range = (load_addr_i_ROM < DEPTH_W);

  always_comb begin
    state_nxt = state;
    fetch_ok  = 1'b0;
    fetch_oob = 1'b0;
    fetch_nop = 1'b0;
    case (state)
      IDLE: begin
        if (chip_enable_i_ROM) begin
          state_nxt = RUN;
          fetch_ok  = pc_in_range;
          fetch_oob = !pc_in_range;
        end
      end
      RUN: begin
        if (!chip_enable_i_ROM) begin
          state_nxt = IDLE;
        end else if (!pc_in_range) begin
          state_nxt = HALT;
          fetch_oob = 1'b1;
        end else begin
          fetch_ok = 1'b1;
        end
      end
      HALT: begin
        if (!chip_enable_i_ROM) state_nxt = IDLE;
        else                    fetch_nop = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load_ok  = load_en_i_ROM && (state == IDLE) && !chip_enable_i_ROM && ld_in_range;
  assign load_bad = load_en_i_ROM && !load_ok;

  always_ff @(posedge clk_i_ROM) begin
    if (!reset_i_ROM) begin
      state            <= IDLE;
      inst_o_ROM       <= '0;
      inst_valid_o_ROM <= 1'b0;
      addr_fault_o_ROM <= 1'b0;
      load_err_o_ROM   <= 1'b0;
      fetch_cnt_o_ROM  <= '0;
    end else begin
      state            <= state_nxt;
      inst_valid_o_ROM <= fetch_ok || fetch_oob || fetch_nop;
      addr_fault_o_ROM <= fetch_oob;
      load_err_o_ROM   <= load_bad;
      if (fetch_ok)                   inst_o_ROM <= mem[pc_addr_i_ROM[AW-1:0]];
      else if (fetch_oob || fetch_nop) inst_o_ROM <= NOP_INSTR;
      if (fetch_ok && fetch_cnt_o_ROM != 16'hFFFF)
        fetch_cnt_o_ROM <= fetch_cnt_o_ROM + 16'd1;
    end
  end

  // Array contents are not reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk_i_ROM) begin
    if (reset_i_ROM && load_ok)
      mem[load_addr_i_ROM[AW-1:0]] <= load_data_i_ROM;
  end

  assign state_o_ROM = state;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp: reset, load, fetch, fault/halt,
// load rejection, reset mid-run and counter saturation.
module tb_inst_rom_resp;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] pc;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] inst;
  logic        valid;
  logic        fault;
  logic        lerr;
  logic [15:0] cnt;
  logic [1:0]  st;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};

  inst_rom_resp #(.DEPTH(64), .NOP_INSTR(NOP)) dut (
    .clk_i_ROM        (clk),
    .reset_i_ROM      (rst_n),
    .chip_enable_i_ROM(en),
    .pc_addr_i_ROM    (pc),
    .load_en_i_ROM    (ld_en),
    .load_addr_i_ROM  (ld_addr),
    .load_data_i_ROM  (ld_data),
    .inst_o_ROM       (inst),
    .inst_valid_o_ROM (valid),
    .addr_fault_o_ROM (fault),
    .load_err_o_ROM   (lerr),
    .fetch_cnt_o_ROM  (cnt),
    .state_o_ROM      (st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pc = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    tick();

    // Seed mem[5] so a write during reset would be visible later
    rst_n = 1'b1; ld_en = 1'b1; ld_addr = 32'd5; ld_data = 32'h1111_1111;
    tick();
    chk("seed_lerr", {31'd0, lerr}, 32'd0);

    // Reset two cycles with fetch and load both requested
    rst_n = 1'b0; en = 1'b1; pc = 32'd5; ld_en = 1'b1; ld_addr = 32'd5; ld_data = 32'hDEAD_BEEF;
    tick(); tick();
    chk("rst_inst",  inst, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_lerr",  {31'd0, lerr}, 32'd0);
    chk("rst_cnt",   {16'd0, cnt}, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);

    // Program load in IDLE
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = i; ld_data = prog[i];
      tick();
      chk("load_lerr", {31'd0, lerr}, 32'd0);
    end
    ld_en = 1'b0;

    // Sequential fetch pc 0..3
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = i;
      tick();
      chk("fetch_inst",  inst, prog[i]);
      chk("fetch_valid", {31'd0, valid}, 32'd1);
    end
    chk("fetch_cnt4",  {16'd0, cnt}, 32'd4);
    chk("fetch_state", {30'd0, st}, 32'd1);

    // mem[5] kept its pre-reset value
    pc = 32'd5;
    tick();
    chk("mem5_survive", inst, 32'h1111_1111);
    chk("fetch_cnt5",   {16'd0, cnt}, 32'd5);

    // Out-of-range in RUN -> NOP, fault pulse, HALT
    pc = 32'd64;
    tick();
    chk("oob_inst",  inst, NOP);
    chk("oob_valid", {31'd0, valid}, 32'd1);
    chk("oob_fault", {31'd0, fault}, 32'd1);
    chk("oob_state", {30'd0, st}, 32'd2);
    chk("oob_cnt",   {16'd0, cnt}, 32'd5);
    pc = 32'd0;
    tick();
    chk("halt_inst",  inst, NOP);
    chk("halt_fault", {31'd0, fault}, 32'd0);
    chk("halt_state", {30'd0, st}, 32'd2);
    chk("halt_cnt",   {16'd0, cnt}, 32'd5);
    en = 1'b0;
    tick();
    chk("dis_state", {30'd0, st}, 32'd0);
    chk("dis_valid", {31'd0, valid}, 32'd0);
    chk("dis_hold",  inst, NOP);

    // High address bits must not alias to a valid word
    en = 1'b1; pc = 32'd1;
    tick();
    chk("alias_pre", inst, prog[1]);
    pc = 32'h4000_0001;
    tick();
    chk("alias_inst",  inst, NOP);
    chk("alias_fault", {31'd0, fault}, 32'd1);
    chk("alias_state", {30'd0, st}, 32'd2);
    en = 1'b0;
    tick();

    // Load attempt during RUN is rejected
    en = 1'b1; pc = 32'd2;
    tick();
    ld_en = 1'b1; ld_addr = 32'd1; ld_data = 32'hFFFF_FFFF; pc = 32'd3;
    tick();
    chk("runld_lerr", {31'd0, lerr}, 32'd1);
    chk("runld_inst", inst, prog[3]);
    ld_en = 1'b0; pc = 32'd1;
    tick();
    chk("runld_lerr_end", {31'd0, lerr}, 32'd0);
    chk("runld_nowrite",  inst, prog[1]);

    // Out-of-range load in IDLE
    en = 1'b0;
    tick();
    ld_en = 1'b1; ld_addr = 32'd64; ld_data = 32'hFFFF_FFFF;
    tick();
    chk("oobld_lerr", {31'd0, lerr}, 32'd1);
    ld_en = 1'b0;
    tick();
    chk("oobld_lerr_end", {31'd0, lerr}, 32'd0);

    // Load and fetch together in IDLE: fetch wins, load rejected
    en = 1'b1; pc = 32'd2; ld_en = 1'b1; ld_addr = 32'd2; ld_data = 32'hFFFF_FFFF;
    tick();
    chk("both_lerr",  {31'd0, lerr}, 32'd1);
    chk("both_inst",  inst, prog[2]);
    chk("both_state", {30'd0, st}, 32'd1);
    ld_en = 1'b0;
    tick();
    chk("both_nowrite", inst, prog[2]);

    // Reset mid-RUN, then first fetch after release
    rst_n = 1'b0;
    tick();
    chk("mid_rst_inst",  inst, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_cnt",   {16'd0, cnt}, 32'd0);
    chk("mid_rst_state", {30'd0, st}, 32'd0);
    rst_n = 1'b1; pc = 32'd0;
    tick();
    chk("post_rst_inst",  inst, prog[0]);
    chk("post_rst_valid", {31'd0, valid}, 32'd1);
    chk("post_rst_cnt",   {16'd0, cnt}, 32'd1);

    // Counter saturation: 1 + 65533 = 0xFFFE, then to 0xFFFF and hold
    for (int i = 0; i < 65533; i++) begin
      pc = i % 4;
      tick();
    end
    chk("cnt_fffe", {16'd0, cnt}, 32'h0000_FFFE);
    pc = 32'd1;
    tick();
    chk("cnt_ffff", {16'd0, cnt}, 32'h0000_FFFF);
    pc = 32'd2;
    tick();
    tick();
    chk("cnt_sat",      {16'd0, cnt}, 32'h0000_FFFF);
    chk("cnt_sat_inst", inst, prog[2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit instruction words, word-addressed.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013: word returned on faulted fetch.
REQ-003 SHALL have port clk_i_ROM  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_i_ROM  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port chip_enable_i_ROM  input  1  fetch request enable from PC stage.
REQ-006 SHALL have port pc_addr_i_ROM  input  32  word address of requested instruction.
REQ-007 SHALL have port load_en_i_ROM  input  1  program-load write strobe.
REQ-008 SHALL have port load_addr_i_ROM  input  32  program-load word address.
REQ-009 SHALL have port load_data_i_ROM  input  32  program-load data word.
REQ-010 SHALL have port inst_o_ROM  output  32  fetched instruction, registered.
REQ-011 SHALL have port inst_valid_o_ROM  output  1  inst_o_ROM holds a fetch result.
REQ-012 SHALL have port addr_fault_o_ROM  output  1  one-cycle pulse: out-of-range fetch address.
REQ-013 SHALL have port load_err_o_ROM  output  1  one-cycle pulse: rejected or out-of-range load.
REQ-014 SHALL have port fetch_cnt_o_ROM  output  16  count of in-range fetches served.
REQ-015 SHALL have port state_o_ROM  output  2  FSM state: 0 IDLE, 1 RUN, 2 HALT.

Function
REQ-016 SHALL implement FSM IDLE/RUN/HALT; encoding 3 unused, recovers to IDLE next cycle.
REQ-017 IDLE: chip_enable_i_ROM=1 -> RUN, same edge performs first fetch; else stay IDLE.
REQ-018 RUN: chip_enable_i_ROM=0 -> IDLE; pc_addr_i_ROM >= DEPTH with enable=1 -> HALT; else stay RUN.
REQ-019 HALT: chip_enable_i_ROM=0 -> IDLE; otherwise stay HALT regardless of address.
REQ-020 Fetch latency SHALL be exactly 1 cycle: address sampled on edge N, inst_o_ROM/inst_valid_o_ROM valid after edge N.
REQ-021 In-range fetch (enable=1, state IDLE/RUN, addr < DEPTH): inst_o_ROM <= mem[addr], inst_valid_o_ROM <= 1, fetch_cnt +1.
REQ-022 Out-of-range fetch: inst_o_ROM <= NOP_INSTR, inst_valid_o_ROM <= 1, addr_fault_o_ROM <= 1 for that cycle only, count unchanged.
REQ-023 In HALT with enable=1: inst_o_ROM <= NOP_INSTR, inst_valid_o_ROM <= 1, no fault pulse, count unchanged.
REQ-024 Enable=0 in any state: inst_valid_o_ROM <= 0; inst_o_ROM holds last value.
REQ-025 Address comparison SHALL use full 32 bits; no wrap-around or truncation of pc_addr_i_ROM.
REQ-026 Load accepted only when state IDLE and enable=0 and load_addr < DEPTH: mem[load_addr] <= load_data next edge.
REQ-027 load_en_i_ROM=1 otherwise (RUN, HALT, enable=1, or addr >= DEPTH): no write, load_err_o_ROM pulses 1 cycle.
REQ-028 Simultaneous load_en and enable=1 in IDLE: fetch proceeds, load rejected per REQ-027.
REQ-029 fetch_cnt_o_ROM SHALL saturate at 16'hFFFF, never wrap.
REQ-030 Memory array SHALL be single write port, single read port, no reset of contents.

Reset
REQ-031 reset_i_ROM=0 at an edge: state IDLE, inst_o_ROM 0, inst_valid 0, addr_fault 0, load_err 0, fetch_cnt 0.
REQ-032 Reset SHALL take priority over fetch and load in the same cycle; pending load not written.
REQ-033 Memory contents SHALL survive reset.
REQ-034 First fetch after reset release honoured on the first edge with reset_i_ROM=1 and enable=1.

Verification
REQ-035 Hold reset_i_ROM=0 two cycles with enable=1, load_en=1 -> all outputs 0, state 0, no memory write.
REQ-036 Load mem[0..3]=00500093,00A00113,002081B3,00000013; enable=1, pc 0..3 -> inst_o matches each one cycle later, valid=1, fetch_cnt=4, state 1.
REQ-037 In RUN, pc=64 -> next cycle inst_o=00000013, valid=1, fault=1 one cycle, state 2; pc=0 -> NOP, no fault; enable=0 -> state 0, valid=0.
REQ-038 load_en=1 addr 1 data FFFFFFFF during RUN -> load_err pulse; later fetch pc=1 returns 00A00113.
REQ-039 Load addr 64 in IDLE -> load_err pulse, no write; reset mid-RUN -> outputs 0, count 0, then pc=0 returns 00500093.
REQ-040 Force fetch_cnt to FFFF via 65535+ in-range fetches -> stays FFFF on further fetches.
